// File: rtl/cnn_core.sv
// Three-stage pipelined convolution core for one output position.
// Stages: all patch x weight products, per-channel kernel sums, then the cross-channel sum plus bias.
module cnn_core #(
  parameter int unsigned CI     = 3,
  parameter int unsigned CO     = 16,
  parameter int unsigned KX     = 3,
  parameter int unsigned KY     = 3,
  parameter int unsigned I_F_BW = 8,
  parameter int unsigned W_BW   = 8,
  parameter int unsigned B_BW   = 8,
  parameter int unsigned M_BW   = 16,
  parameter int unsigned AK_BW  = 20,
  parameter int unsigned ACI_BW = 22,
  parameter int unsigned O_F_BW = 23
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          soft_reset_i,
  input  logic [CO*CI*KX*KY*W_BW-1:0]   cnn_weight_i,
  input  logic [CO*B_BW-1:0]            cnn_bias_i,
  input  logic                          in_valid_i,
  input  logic [CI*KX*KY*I_F_BW-1:0]    in_fmap_i,
  output logic                          ot_valid_o,
  output logic [CO*O_F_BW-1:0]          ot_fmap_o
);

  localparam int unsigned KK = KX * KY;

  logic v1, v2, v3;

  logic [M_BW-1:0]   mul_d  [CO][CI][KK];
  logic [M_BW-1:0]   mul_q  [CO][CI][KK];
  logic [AK_BW-1:0]  ksum_d [CO][CI];
  logic [AK_BW-1:0]  ksum_q [CO][CI];
  logic [O_F_BW-1:0] osum_d [CO];
  logic [O_F_BW-1:0] osum_q [CO];

  for (genvar go = 0; go < CO; go++) begin : g_och
    for (genvar gi = 0; gi < CI; gi++) begin : g_ich
      logic [AK_BW-1:0] kacc;

      for (genvar gk = 0; gk < KK; gk++) begin : g_tap
        assign mul_d[go][gi][gk] =
          M_BW'(in_fmap_i[(gi*KK + gk)*I_F_BW +: I_F_BW]) *
          M_BW'(cnn_weight_i[((go*CI + gi)*KK + gk)*W_BW +: W_BW]);
      end

      always_comb begin
        kacc = '0;
        for (int unsigned k = 0; k < KK; k++) begin
          kacc = kacc + AK_BW'(mul_q[go][gi][k]);
        end
      end

      assign ksum_d[go][gi] = kacc;
    end

    logic [ACI_BW-1:0] cacc;

    always_comb begin
      cacc = '0;
      for (int unsigned i = 0; i < CI; i++) begin
        cacc = cacc + ACI_BW'(ksum_q[go][i]);
      end
    end

    // Bias joins at the last stage so the extra output bit only covers its carry.
    assign osum_d[go] = O_F_BW'(cacc) + O_F_BW'(cnn_bias_i[go*B_BW +: B_BW]);
    assign ot_fmap_o[go*O_F_BW +: O_F_BW] = osum_q[go];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (soft_reset_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= in_valid_i;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_q <= '{default: '0};
    end else if (soft_reset_i) begin
      mul_q <= '{default: '0};
    end else if (in_valid_i) begin
      mul_q <= mul_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ksum_q <= '{default: '0};
    end else if (soft_reset_i) begin
      ksum_q <= '{default: '0};
    end else if (v1) begin
      ksum_q <= ksum_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      osum_q <= '{default: '0};
    end else if (soft_reset_i) begin
      osum_q <= '{default: '0};
    end else if (v2) begin
      osum_q <= osum_d;
    end
  end

  assign ot_valid_o = v3;

endmodule

// File: tb/tb_cnn_core.sv
// Directed scoreboard bench for cnn_core: expected results queued at issue, checked as outputs emerge.
module tb_cnn_core;

  localparam int unsigned CI     = 3;
  localparam int unsigned CO     = 16;
  localparam int unsigned KX     = 3;
  localparam int unsigned KY     = 3;
  localparam int unsigned I_F_BW = 8;
  localparam int unsigned W_BW   = 8;
  localparam int unsigned B_BW   = 8;
  localparam int unsigned M_BW   = 16;
  localparam int unsigned AK_BW  = 20;
  localparam int unsigned ACI_BW = 22;
  localparam int unsigned O_F_BW = 23;
  localparam int unsigned KK     = KX * KY;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        soft_reset_i;
  logic [CO*CI*KK*W_BW-1:0]    cnn_weight_i;
  logic [CO*B_BW-1:0]          cnn_bias_i;
  logic                        in_valid_i;
  logic [CI*KK*I_F_BW-1:0]     in_fmap_i;
  logic                        ot_valid_o;
  logic [CO*O_F_BW-1:0]        ot_fmap_o;

  always #5 clk = ~clk;

  cnn_core #(
    .CI(CI), .CO(CO), .KX(KX), .KY(KY),
    .I_F_BW(I_F_BW), .W_BW(W_BW), .B_BW(B_BW),
    .M_BW(M_BW), .AK_BW(AK_BW), .ACI_BW(ACI_BW), .O_F_BW(O_F_BW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_reset_i (soft_reset_i),
    .cnn_weight_i (cnn_weight_i),
    .cnn_bias_i   (cnn_bias_i),
    .in_valid_i   (in_valid_i),
    .in_fmap_i    (in_fmap_i),
    .ot_valid_o   (ot_valid_o),
    .ot_fmap_o    (ot_fmap_o)
  );

  logic [7:0] fm [CI][KY][KX];
  logic [7:0] wt [CO][CI][KY][KX];
  logic [7:0] bs [CO];

  logic [CO*O_F_BW-1:0] sb [$];
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [CO*O_F_BW-1:0] model();
    logic [CO*O_F_BW-1:0] r;
    longint s;
    r = '0;
    for (int o = 0; o < CO; o++) begin
      s = longint'(bs[o]);
      for (int i = 0; i < CI; i++)
        for (int y = 0; y < KY; y++)
          for (int x = 0; x < KX; x++)
            s += longint'(fm[i][y][x]) * longint'(wt[o][i][y][x]);
      r[o*O_F_BW +: O_F_BW] = s[O_F_BW-1:0];
    end
    return r;
  endfunction

  task automatic apply();
    for (int i = 0; i < CI; i++)
      for (int y = 0; y < KY; y++)
        for (int x = 0; x < KX; x++)
          in_fmap_i[(i*KK + y*KX + x)*I_F_BW +: I_F_BW] = fm[i][y][x];
    for (int o = 0; o < CO; o++) begin
      cnn_bias_i[o*B_BW +: B_BW] = bs[o];
      for (int i = 0; i < CI; i++)
        for (int y = 0; y < KY; y++)
          for (int x = 0; x < KX; x++)
            cnn_weight_i[(o*CI*KK + i*KK + y*KX + x)*W_BW +: W_BW] = wt[o][i][y][x];
    end
  endtask

  task automatic fill(input logic [7:0] f, input logic [7:0] w, input logic [7:0] b);
    for (int i = 0; i < CI; i++)
      for (int y = 0; y < KY; y++)
        for (int x = 0; x < KX; x++) begin
          fm[i][y][x] = f;
          for (int o = 0; o < CO; o++) wt[o][i][y][x] = w;
        end
    for (int o = 0; o < CO; o++) bs[o] = b;
  endtask

  // Present one patch for one edge; in_valid_i stays high for the caller to drop or reuse.
  task automatic send();
    apply();
    in_valid_i = 1'b1;
    sb.push_back(model());
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (ot_valid_o === 1'b1) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        logic [CO*O_F_BW-1:0] e;
        e = sb.pop_front();
        for (int o = 0; o < CO; o++)
          check($sformatf("och%0d", o), 64'(ot_fmap_o[o*O_F_BW +: O_F_BW]), 64'(e[o*O_F_BW +: O_F_BW]));
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    soft_reset_i = 1'b0;
    fill(8'd5, 8'd3, 8'd1);
    apply();
    in_valid_i   = 1'b1;

    // Async reset holds everything at zero even with valid input present.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(ot_valid_o), 64'd0);
    check("rst_fmap_zero", 64'(ot_fmap_o === '0), 64'd1);
    in_valid_i = 1'b0;
    reset_n    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_valid", 64'(ot_valid_o), 64'd0);
    check("post_rst_fmap_zero", 64'(ot_fmap_o === '0), 64'd1);

    // Unit values with explicit latency probe.
    fill(8'd1, 8'd1, 8'd0);
    send();
    idle();
    check("lat_edge1", 64'(ot_valid_o), 64'd0);
    @(posedge clk); #1;
    check("lat_edge2", 64'(ot_valid_o), 64'd0);
    @(posedge clk); #1;
    check("lat_edge3", 64'(ot_valid_o), 64'd1);
    check("unit_och0", 64'(ot_fmap_o[0 +: O_F_BW]), 64'd27);
    drain("drain_unit");

    // Bias och = och.
    for (int o = 0; o < CO; o++) bs[o] = 8'(o);
    send();
    idle();
    drain("drain_bias");
    check("bias_och15", 64'(ot_fmap_o[15*O_F_BW +: O_F_BW]), 64'd42);

    // Maximum operands.
    fill(8'd255, 8'd255, 8'd255);
    send();
    idle();
    drain("drain_max");
    check("max_och7", 64'(ot_fmap_o[7*O_F_BW +: O_F_BW]), 64'd1755930);

    // Single-element selectivity confirms bit ordering.
    fill(8'd0, 8'd0, 8'd0);
    fm[1][2][0]    = 8'd7;
    wt[5][1][2][0] = 8'd9;
    send();
    idle();
    drain("drain_sel");
    check("sel_och5", 64'(ot_fmap_o[5*O_F_BW +: O_F_BW]), 64'd63);
    check("sel_och4", 64'(ot_fmap_o[4*O_F_BW +: O_F_BW]), 64'd0);

    // Back-to-back stream, then hold after valid drops.
    fill(8'd1, 8'd1, 8'd0);
    send();
    fill(8'd2, 8'd1, 8'd0);
    send();
    fill(8'd3, 8'd1, 8'd0);
    send();
    idle();
    drain("drain_stream");
    repeat (2) @(posedge clk);
    #1;
    check("hold_valid", 64'(ot_valid_o), 64'd0);
    check("hold_och0", 64'(ot_fmap_o[0 +: O_F_BW]), 64'd81);

    // Continuous valid with a constant patch.
    fill(8'd2, 8'd3, 8'd4);
    repeat (5) send();
    idle();
    drain("drain_const");

    // Soft reset one cycle after a patch discards it.
    fill(8'd4, 8'd1, 8'd0);
    send();
    idle();
    soft_reset_i = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    soft_reset_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("srst_valid", 64'(ot_valid_o), 64'd0);
    end
    check("srst_fmap_zero", 64'(ot_fmap_o === '0), 64'd1);

    // Soft reset wins over a simultaneous valid.
    apply();
    in_valid_i   = 1'b1;
    soft_reset_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i   = 1'b0;
    soft_reset_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("srst_prio_valid", 64'(ot_valid_o), 64'd0);
    end

    // Normal operation resumes the cycle after soft reset drops.
    soft_reset_i = 1'b1;
    @(posedge clk); #1;
    soft_reset_i = 1'b0;
    send();
    idle();
    drain("drain_after_srst");
    check("after_srst_och3", 64'(ot_fmap_o[3*O_F_BW +: O_F_BW]), 64'd108);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
